// File: rtl/conv_pkg.sv
// Shared widths, output limits and the ReLU / round-half-up / saturate arithmetic
// used by the convolver result stage.
package conv_pkg;
    localparam int DATA_WIDTH  = 32;
    localparam int OUT_WIDTH   = 16;
    localparam int SHIFT_WIDTH = 5;

    localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    typedef struct packed {
        logic [OUT_WIDTH-1:0] data;
        logic                 sat;
    } requant_t;

    function automatic requant_t requant(
        input logic signed [DATA_WIDTH-1:0]  x,
        input logic                          relu_en,
        input logic        [SHIFT_WIDTH-1:0] shift
    );
        logic signed [DATA_WIDTH:0] v;
        logic signed [DATA_WIDTH:0] half;
        logic signed [DATA_WIDTH:0] y;
        logic signed [DATA_WIDTH:0] max_ext;
        logic signed [DATA_WIDTH:0] min_ext;
        logic        [SHIFT_WIDTH-1:0] sh;
        requant_t r;

        v = {x[DATA_WIDTH-1], x};
        if (relu_en && x[DATA_WIDTH-1]) begin
            v = '0;
        end
        sh = (int'(shift) > DATA_WIDTH-1) ? SHIFT_WIDTH'(DATA_WIDTH-1) : shift;
        // One extra bit of headroom keeps the rounding add from wrapping.
        half = '0;
        if (sh != '0) begin
            half = (DATA_WIDTH+1)'(1) << (sh - SHIFT_WIDTH'(1));
        end
        y = (v + half) >>> sh;

        max_ext = {{(DATA_WIDTH+1-OUT_WIDTH){1'b0}}, OUT_MAX};
        min_ext = {{(DATA_WIDTH+1-OUT_WIDTH){1'b1}}, OUT_MIN};
        r.sat = 1'b0;
        if (y > max_ext) begin
            r.data = OUT_MAX;
            r.sat  = 1'b1;
        end else if (y < min_ext) begin
            r.data = OUT_MIN;
            r.sat  = 1'b1;
        end else begin
            r.data = y[OUT_WIDTH-1:0];
        end
        return r;
    endfunction
endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word fall-through FIFO: rdata shows the head whenever the FIFO is non-empty,
// and reads as zero when empty.
module sync_fifo_fwft #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4,
    localparam int PW        = $clog2(DEPTH),
    localparam int CW        = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  empty,
    output logic [CW-1:0]         count
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    always_comb begin
        pop_ok   = pop && (count_q != '0);
        push_ok  = push && ((count_q != CW'(DEPTH)) || pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = empty ? '0 : mem[rd_ptr_q];
endmodule

// File: rtl/conv_result_stage.sv
// Adder-tree result stage: sample (S1), requantise (S2), then buffer in a FWFT FIFO.
// Input flow control reserves a FIFO slot for every result in flight, so the pipeline never stalls.
module conv_result_stage
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH  = conv_pkg::DATA_WIDTH,
    parameter int OUT_WIDTH   = conv_pkg::OUT_WIDTH,
    parameter int SHIFT_WIDTH = conv_pkg::SHIFT_WIDTH,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   relu_en,
    input  logic [SHIFT_WIDTH-1:0] shift,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   sat_sticky,
    input  logic                   sat_clr
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                   s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0]  s1_data_q, s1_data_d;
    logic                   s1_relu_q, s1_relu_d;
    logic [SHIFT_WIDTH-1:0] s1_shift_q, s1_shift_d;
    logic                   s2_valid_q, s2_valid_d;
    logic [OUT_WIDTH-1:0]   s2_data_q, s2_data_d;
    logic                   sat_sticky_q, sat_sticky_d;
    logic [CW-1:0]          fifo_count;
    logic                   fifo_empty;
    logic                   accept;
    requant_t               rq;

    always_comb begin
        // Credits: buffered entries plus results still travelling through S1/S2.
        in_ready     = (int'(fifo_count) + int'(s1_valid_q) + int'(s2_valid_q)) < FIFO_DEPTH;
        accept       = in_valid && in_ready;
        s1_valid_d   = accept;
        s1_data_d    = accept ? in_data : s1_data_q;
        s1_relu_d    = accept ? relu_en : s1_relu_q;
        s1_shift_d   = accept ? shift   : s1_shift_q;
        rq           = requant(s1_data_q, s1_relu_q, s1_shift_q);
        s2_valid_d   = s1_valid_q;
        s2_data_d    = s1_valid_q ? rq.data : s2_data_q;
        // A fresh saturation beats a simultaneous clear.
        sat_sticky_d = (sat_sticky_q && !sat_clr) || (s1_valid_q && rq.sat);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            s1_relu_q    <= 1'b0;
            s1_shift_q   <= '0;
            s2_valid_q   <= 1'b0;
            s2_data_q    <= '0;
            sat_sticky_q <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_data_q    <= s1_data_d;
            s1_relu_q    <= s1_relu_d;
            s1_shift_q   <= s1_shift_d;
            s2_valid_q   <= s2_valid_d;
            s2_data_q    <= s2_data_d;
            sat_sticky_q <= sat_sticky_d;
        end
    end

    sync_fifo_fwft #(
        .DATA_WIDTH (OUT_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (s2_valid_q),
        .pop   (out_ready),
        .wdata (s2_data_q),
        .rdata (out_data),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign out_valid  = !fifo_empty;
    assign sat_sticky = sat_sticky_q;
endmodule

// File: tb/tb_conv_result_stage.sv
// Directed and random stimulus for conv_result_stage with an in-order scoreboard
// that also tracks pipeline latency and input credits.
`timescale 1ns/1ps
module tb_conv_result_stage;
    import conv_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        relu_en = 1'b0;
    logic        out_ready = 1'b0;
    logic        sat_clr = 1'b0;
    logic [31:0] in_data = '0;
    logic [4:0]  shift = '0;
    logic        in_ready, out_valid, sat_sticky;
    logic [15:0] out_data;

    always #5 clk = ~clk;

    conv_result_stage #(
        .DATA_WIDTH  (32),
        .OUT_WIDTH   (16),
        .SHIFT_WIDTH (5),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .relu_en    (relu_en),
        .shift      (shift),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .sat_sticky (sat_sticky),
        .sat_clr    (sat_clr)
    );

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } ent_t;

    ent_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          pop_cnt = 0;
    logic        last_acc = 1'b0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge with inputs already driven; checks, records, then advances one edge.
    task automatic cycle();
        logic     exp_valid;
        ent_t     e;
        requant_t r;
        exp_valid = (exp_q.size() != 0) && (cyc - exp_q[0].cyc >= 3);
        check("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
        check("no_overflow", 32'(exp_q.size() <= DEPTH), 32'(1));
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        if (prev_stall) check("stall_hold", 32'(out_data), 32'(prev_data));
        if (exp_valid) check("out_data", 32'(out_data), 32'(exp_q[0].data));
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        if (exp_valid && out_ready) begin
            void'(exp_q.pop_front());
            pop_cnt++;
        end
        last_acc = in_valid && in_ready;
        if (last_acc) begin
            r     = requant(in_data, relu_en, shift);
            e.data = r.data;
            e.cyc  = cyc;
            exp_q.push_back(e);
            acc_cnt++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 60) begin
            cycle();
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'(0));
    endtask

    task automatic send_one(input logic [31:0] d, input logic r, input logic [4:0] s,
                            input logic [15:0] exp, input string tag);
        int waited;
        in_valid  = 1'b1;
        in_data   = d;
        relu_en   = r;
        shift     = s;
        out_ready = 1'b1;
        check({tag, "_accept"}, 32'(in_ready), 32'(1));
        cycle();
        in_valid = 1'b0;
        waited   = 0;
        while (!out_valid && waited < 10) begin
            cycle();
            waited++;
        end
        check({tag, "_latency"}, 32'(waited), 32'(2));
        check(tag, 32'(out_data), 32'(exp));
        $display("send %s in=%0d relu=%0d shift=%0d out=%0d", tag, $signed(d), r, s, $signed(out_data));
        cycle();
    endtask

    initial begin
        int acc_base, pop_base;

        // Reset
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_sat", 32'(sat_sticky), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(1));

        // Basic and rounding
        send_one(32'd1000, 1'b0, 5'd2, 16'd250, "basic");
        check("basic_sat", 32'(sat_sticky), 32'(0));
        send_one(32'd6, 1'b0, 5'd2, 16'd2, "rnd_pos_tie");
        send_one(-32'sd6, 1'b0, 5'd2, 16'hFFFF, "rnd_neg_tie");
        send_one(-32'sd7, 1'b0, 5'd1, 16'hFFFD, "rnd_neg7");
        send_one(32'd5, 1'b0, 5'd0, 16'd5, "shift0");

        // ReLU and saturation
        send_one(-32'sd500, 1'b1, 5'd0, 16'd0, "relu");
        check("relu_sat", 32'(sat_sticky), 32'(0));
        send_one(32'd70000, 1'b0, 5'd0, 16'h7FFF, "sat_max");
        check("sat_max_sticky", 32'(sat_sticky), 32'(1));
        sat_clr = 1'b1;
        cycle();
        sat_clr = 1'b0;
        check("sat_clr", 32'(sat_sticky), 32'(0));
        send_one(-32'sd70000, 1'b0, 5'd0, 16'h8000, "sat_min");
        check("sat_min_sticky", 32'(sat_sticky), 32'(1));

        // Clear and new saturation on the same edge
        in_valid  = 1'b1;
        in_data   = 32'd70000;
        shift     = 5'd0;
        relu_en   = 1'b0;
        sat_clr   = 1'b1;
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        check("clr_alone", 32'(sat_sticky), 32'(0));
        cycle();
        check("set_wins", 32'(sat_sticky), 32'(1));
        sat_clr = 1'b0;
        drain();

        // Backpressure
        acc_base  = acc_cnt;
        pop_base  = pop_cnt;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'd1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (last_acc) in_data = in_data + 32'd1;
        end
        check("bp_accepts", 32'(acc_cnt - acc_base), 32'(4));
        check("bp_in_ready", 32'(in_ready), 32'(0));
        check("bp_head", 32'(out_data), 32'(1));
        drain();
        check("bp_pops", 32'(pop_cnt - pop_base), 32'(4));

        // Random valid/ready
        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 9) < 7);
            in_data   = $urandom;
            relu_en   = 1'($urandom_range(0, 1));
            shift     = 5'($urandom_range(0, 31));
            cycle();
        end
        drain();
        check("rand_balance", 32'(pop_cnt), 32'(acc_cnt));

        // Reset with results in flight and buffered
        relu_en   = 1'b0;
        shift     = 5'd0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'd70000;
        cycle();
        in_data = 32'd1;
        cycle();
        in_data = 32'd2;
        cycle();
        in_data = 32'd3;
        cycle();
        in_valid = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'(1));
        check("pre_rst_sat", 32'(sat_sticky), 32'(1));
        check("pre_rst_full", 32'(exp_q.size()), 32'(4));
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'(0));
        check("mid_rst_sat", 32'(sat_sticky), 32'(0));
        check("mid_rst_data", 32'(out_data), 32'(0));
        exp_q.delete();
        prev_stall = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (5) cycle();
        send_one(32'd400, 1'b0, 5'd2, 16'd100, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
